// File: rtl/mdu_iter_if.sv
// mdu_iter_if: request/result bundle between the E stage and the multiply/divide unit.
interface mdu_iter_if #(parameter int WIDTH = 32);
    logic start;
    logic cancel;
    logic [1:0] op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic busy;
    logic valid;
    logic div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master(output start, cancel, op, a, b, input busy, valid, div_zero, hi, lo);
    modport slave(input start, cancel, op, a, b, output busy, valid, div_zero, hi, lo);
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit producing HI/LO, one bit per cycle.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter bit FAST_MUL = 0
) (
    input logic clk,
    input logic rst,
    mdu_iter_if.slave m
);
    localparam int W2 = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state;
    logic busy, valid, div_zero, sa, sb, bz;
    logic [1:0] op;
    logic [WIDTH-1:0] hi, lo, a_raw, d;
    logic [W2-1:0] acc;
    logic [CW-1:0] cnt;
    logic a_neg, b_neg, go, fast;
    logic [WIDTH-1:0] ma, mb, q, r, fix_hi, fix_lo;
    logic [WIDTH:0] mul_sum, div_sh, div_diff;
    logic [W2-1:0] mul_next, div_next, prod;
    assign a_neg = m.op[0] & m.a[WIDTH-1];
    assign b_neg = m.op[0] & m.b[WIDTH-1];
    assign ma = a_neg ? -m.a : m.a;
    assign mb = b_neg ? -m.b : m.b;
    assign go = m.start & ~m.cancel;
    assign fast = FAST_MUL & ~m.op[1];
    // acc = {partial product, remaining multiplier} or {remainder, dividend/quotient}
    assign mul_sum = {1'b0, acc[W2-1:WIDTH]} + {1'b0, (acc[0] ? d : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};
    assign div_sh = {acc[W2-1:WIDTH], acc[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, d};
    assign div_next = div_diff[WIDTH] ? {div_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                      : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    assign prod = (sa ^ sb) ? -acc : acc;
    assign q = acc[WIDTH-1:0];
    assign r = acc[W2-1:WIDTH];
    assign fix_hi = !op[1] ? prod[W2-1:WIDTH] : bz ? a_raw : sa ? -r : r;
    assign fix_lo = !op[1] ? prod[WIDTH-1:0] : bz ? {WIDTH{1'b1}} : (sa ^ sb) ? -q : q;
    assign m.busy = busy;
    assign m.valid = valid;
    assign m.div_zero = div_zero;
    assign m.hi = hi;
    assign m.lo = lo;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            busy <= 1'b0;
            valid <= 1'b0;
            div_zero <= 1'b0;
            hi <= '0;
            lo <= '0;
            cnt <= '0;
            acc <= '0;
            d <= '0;
            a_raw <= '0;
            op <= '0;
            sa <= 1'b0;
            sb <= 1'b0;
            bz <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    busy <= 1'b0;
                    if (go) begin
                        op <= m.op;
                        sa <= a_neg;
                        sb <= b_neg;
                        bz <= m.b == '0;
                        a_raw <= m.a;
                        cnt <= '0;
                        d <= m.op[1] ? mb : ma;
                        acc <= fast ? W2'(ma) * W2'(mb)
                                    : m.op[1] ? {{WIDTH{1'b0}}, ma} : {{WIDTH{1'b0}}, mb};
                        state <= fast ? FIX : CALC;
                        busy <= 1'b1;
                    end
                end
                CALC: begin
                    if (m.cancel) begin
                        state <= IDLE;
                        busy <= 1'b0;
                    end else begin
                        acc <= op[1] ? div_next : mul_next;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    state <= m.cancel ? IDLE : DONE;
                    busy <= 1'b0;
                    if (!m.cancel) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                        div_zero <= op[1] & bz;
                        valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
